// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan controller and decoder.
//   - Glyphs are {A,B,C,D,E,F,G}, active high.
//   - FSM state encodings for the slot blanking FSM.
//   - clog2 helper for sizing counters and indices.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to 7-segment decoder.
//   i_bcd  in  4  BCD nibble
//   o_seg  out 7  {A,B,C,D,E,F,G}, active high; nibbles A..F give a dash
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed driver for a common-segment BCD LED display.
//   Each digit gets a PRESCALE-cycle slot whose first BLANK_CYCLES cycles have
//   all anodes off. New values arrive over valid/ready and are committed only at
//   a frame boundary so a frame never mixes two values.
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   async active-low reset (release synchronised internally)
//   load_valid  in   load_data valid
//   load_ready  out  controller can accept load_data
//   load_data   in   packed BCD, digit i = [4i+3:4i], digit 0 rightmost
//   seg         out  {A..G}, active high
//   an_n        out  digit enables, active low
//   digit_idx   out  digit currently owning its slot
//   invalid     out  some displayed nibble is > 9
// Build option: define LEADING_ZERO_BLANK_EN to blank (seg=0, anode still on)
//   digits above the most-significant non-zero digit; digit 0 is always shown.
// BLANK_CYCLES must be >= 1 and < PRESCALE.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [4*NUM_DIGITS-1:0]      load_data,
  output logic [6:0]                   seg,
  output logic [NUM_DIGITS-1:0]        an_n,
  output logic [clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                         invalid
);

  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam int CNT_W = clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_BLKM1 = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  // Reset asserts immediately, releases two clocks after rst_n rises.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  state_e                  r_state, w_state_nxt;
  logic [4*NUM_DIGITS-1:0] r_disp, r_pend;
  logic                    r_pending, r_ready;
  logic [NUM_DIGITS-1:0]   r_an_n, w_an_n;
  logic [6:0]              r_seg, w_seg, w_dec_seg;
  logic                    r_invalid, w_invalid;
  logic [3:0]              w_nib;
  logic                    w_wrap, w_frame, w_xfer, w_lz_blank;

  assign w_wrap  = (r_cnt == CNT_MAX);
  assign w_frame = w_wrap && (r_idx == IDX_MAX);
  assign w_xfer  = load_valid && r_ready;

  // Slot prescaler and digit counter
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_BLANK;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state. Registered, so the edge is taken one count early to make
  // state read SHOW exactly when cnt == BLANK_CYCLES.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BLANK: if (r_cnt == CNT_BLKM1) w_state_nxt = ST_SHOW;
      ST_SHOW:  if (w_wrap)             w_state_nxt = ST_BLANK;
      default:                          w_state_nxt = ST_BLANK;
    endcase
  end

  // Shared decoder fed by a digit mux
  always_comb begin
    w_nib = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r_idx == IDX_W'(i)) w_nib = r_disp[4*i +: 4];
  end

  seg7_decode u_dec (
    .i_bcd (w_nib),
    .o_seg (w_dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Highest digit holding any non-zero nibble (invalid nibbles included);
  // stays 0 for an all-zero value so digit 0 still lights.
  logic [IDX_W-1:0] w_msd;
  always_comb begin
    w_msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (r_disp[4*i +: 4] != 4'd0) w_msd = IDX_W'(i);
    w_lz_blank = (r_idx > w_msd);
  end
`else
  assign w_lz_blank = 1'b0;
`endif

  always_comb begin
    w_invalid = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r_disp[4*i +: 4] > 4'd9) w_invalid = 1'b1;
  end

  // FSM: outputs (registered below)
  always_comb begin
    w_an_n = '1;
    w_seg  = SEG_BLANK;
    if (r_state == ST_SHOW) begin
      w_an_n[r_idx] = 1'b0;
      w_seg         = w_lz_blank ? SEG_BLANK : w_dec_seg;
    end
  end

  // Handshake / commit. The commit branch wins, but the two never coincide:
  // pending implies ready is low, so no transfer is possible that cycle.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_disp    <= '0;
      r_pend    <= '0;
      r_pending <= 1'b0;
      r_ready   <= 1'b1;
    end else if (w_frame && r_pending) begin
      r_disp    <= r_pend;
      r_pending <= 1'b0;
      r_ready   <= 1'b1;
    end else if (w_xfer) begin
      r_pend    <= load_data;
      r_pending <= 1'b1;
      r_ready   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_an_n    <= '1;
      r_seg     <= SEG_BLANK;
      r_invalid <= 1'b0;
    end else begin
      r_an_n    <= w_an_n;
      r_seg     <= w_seg;
      r_invalid <= w_invalid;
    end
  end

  assign load_ready = r_ready;
  assign seg        = r_seg;
  assign an_n       = r_an_n;
  assign digit_idx  = r_idx;
  assign invalid    = r_invalid;

endmodule
